cpu6_instenc: RTL and testbench

Instruction encoder for the cpu6 core: takes field-level requests (kind, rd, rs1, rs2, imm) over a valid/ready handshake. It range-checks each request, assembles the 32-bit RV32I machine word, and queues the word in a small FIFO for a downstream consumer.
- Consumers: the debug/boot instruction injector and self-test sequences.
- Covered kinds: exactly the instructions cpu6 decodes.
- Rejected requests produce an error pulse and a saturating error count instead of an instruction.

---
 rtl/cpu6_instenc.sv | 196 +++++++++++++++++++
 tb/tb_cpu6_instenc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_instenc.sv
// cpu6_instenc: field-level RV32I instruction encoder with output FIFO.
// Accepts (kind, rd, rs1, rs2, imm) requests on a valid/ready handshake,
// range-checks them, and either queues the encoded 32-bit word or
// reports a rejection with a code and a saturating error count.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   req_valid / req_ready    request handshake (ready = FIFO not full)
//   req_kind                 0 LW,1 SW,2 ADDI,3 ADD,4 SUB,5 BEQ,6 BNE,7 JALR,8 CSRRW
//   req_rd/rs1/rs2, req_imm  instruction fields (imm = CSR address for CSRRW)
//   inst_valid / inst_ready  FIFO head handshake, inst = head word
//   err_valid, err_code      one-cycle rejection pulse and reason (1/2/3)
//   err_count                saturating count of rejected requests
module cpu6_instenc #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_kind,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned XW   = 32;
  localparam int unsigned ECW  = 2;
  localparam int unsigned ECNT = 8;

  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [ECNT-1:0] CNT_MAX = '1;

  localparam logic [3:0] K_LW    = 4'd0;
  localparam logic [3:0] K_SW    = 4'd1;
  localparam logic [3:0] K_ADDI  = 4'd2;
  localparam logic [3:0] K_ADD   = 4'd3;
  localparam logic [3:0] K_SUB   = 4'd4;
  localparam logic [3:0] K_BEQ   = 4'd5;
  localparam logic [3:0] K_BNE   = 4'd6;
  localparam logic [3:0] K_JALR  = 4'd7;
  localparam logic [3:0] K_CSRRW = 4'd8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [ECW-1:0] E_KIND  = 2'd1;
  localparam logic [ECW-1:0] E_RANGE = 2'd2;
  localparam logic [ECW-1:0] E_ALIGN = 2'd3;

  logic [XW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [XW-1:0]   inst_q, inst_d;
  logic            err_valid_q, err_valid_d;
  logic [ECW-1:0]  err_code_q, err_code_d;
  logic [ECNT-1:0] err_count_q, err_count_d;

  logic [XW-1:0]  word_c;
  logic           rej_c;
  logic [ECW-1:0] code_c;
  logic           imm12_ok_c, imm13_ok_c, csr_ok_c;
  logic           accept_c, push_c, pop_c;

  // Sign-extension checks: the upper bits must replicate the field's sign bit.
  assign imm12_ok_c = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign imm13_ok_c = (&req_imm[31:12]) | ~(|req_imm[31:12]);
  assign csr_ok_c   = ~(|req_imm[31:12]);

  // Field assembly and range checking, highest-priority error first.
  always_comb begin : encode
    word_c = '0;
    rej_c  = 1'b0;
    code_c = '0;
    case (req_kind)
      K_LW, K_ADDI, K_JALR: begin
        word_c = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_IMM};
        if (req_kind == K_LW)   word_c = {req_imm[11:0], req_rs1, 3'b010, req_rd, OP_LOAD};
        if (req_kind == K_JALR) word_c = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
        if (!imm12_ok_c) begin
          rej_c  = 1'b1;
          code_c = E_RANGE;
        end
      end
      K_SW: begin
        word_c = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OP_STORE};
        if (!imm12_ok_c) begin
          rej_c  = 1'b1;
          code_c = E_RANGE;
        end
      end
      K_ADD:   word_c = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OP_REG};
      K_SUB:   word_c = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OP_REG};
      K_BEQ, K_BNE: begin
        word_c = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                  (req_kind == K_BNE) ? 3'b001 : 3'b000,
                  req_imm[4:1], req_imm[11], OP_BRANCH};
        if (!imm13_ok_c) begin
          rej_c  = 1'b1;
          code_c = E_RANGE;
        end else if (req_imm[0]) begin
          rej_c  = 1'b1;
          code_c = E_ALIGN;
        end
      end
      K_CSRRW: begin
        word_c = {req_imm[11:0], req_rs1, 3'b001, req_rd, OP_SYSTEM};
        if (!csr_ok_c) begin
          rej_c  = 1'b1;
          code_c = E_RANGE;
        end
      end
      default: begin
        rej_c  = 1'b1;
        code_c = E_KIND;
      end
    endcase
  end

  assign accept_c = req_valid & ready_q;
  assign push_c   = accept_c & ~rej_c;
  assign pop_c    = valid_q & inst_ready;

  // FIFO pointer/count update and the registered head word.
  always_comb begin : next_state
    wr_ptr_d    = wr_ptr_q + AW'(push_c);
    rd_ptr_d    = rd_ptr_q + AW'(pop_c);
    count_d     = count_q + CW'(push_c) - CW'(pop_c);
    ready_d     = (count_d != FULL);
    valid_d     = (count_d != '0);
    inst_d      = inst_q;
    // The new head is the word being written this cycle when it lands at rd_ptr_d.
    if (count_d != '0) begin
      if (push_c && (rd_ptr_d == wr_ptr_q)) inst_d = word_c;
      else                                  inst_d = mem_q[rd_ptr_d];
    end
    err_valid_d = accept_c & rej_c;
    err_code_d  = (accept_c & rej_c) ? code_c : err_code_q;
    err_count_d = err_count_q;
    if (accept_c && rej_c && (err_count_q != CNT_MAX)) err_count_d = err_count_q + ECNT'(1);
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin : storage
    if (push_c) mem_q[wr_ptr_q] <= word_c;
  end

  always_ff @(posedge clk) begin : regs
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_ready  = ready_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_cpu6_instenc.sv
// Directed-vector bench for cpu6_instenc with hand-computed instruction words.
module tb_cpu6_instenc;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_kind;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  cpu6_instenc #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; caller guarantees req_ready is high.
  task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // ADDI rd=1 rs1=0 word for a small positive immediate.
  function automatic logic [31:0] addi_w(input int imm);
    return (32'(imm) << 20) | 32'h0000_0093;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst); end
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL rst_err got %b/%0d exp 0/0", err_valid, err_code); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_basic();
    inst_ready = 1'b1;
    send(4'd2, 5'd1, 5'd0, 5'd0, 32'd5);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h00500093) begin errors++; $display("FAIL addi got %b/%h exp 1/00500093", inst_valid, inst); end
    send(4'd3, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h002081B3) begin errors++; $display("FAIL add got %b/%h exp 1/002081b3", inst_valid, inst); end
    send(4'd4, 5'd3, 5'd1, 5'd2, 32'd0);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h402081B3) begin errors++; $display("FAIL sub got %b/%h exp 1/402081b3", inst_valid, inst); end
    send(4'd2, 5'd1, 5'd0, 5'd0, 32'h0000_07FF);
    checks++; if (inst !== 32'h7FF00093) begin errors++; $display("FAIL addi_max got %h exp 7ff00093", inst); end
    send(4'd2, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
    checks++; if (inst !== 32'h80000093 || err_valid !== 1'b0) begin errors++; $display("FAIL addi_min got %h/%b exp 80000093/0", inst, err_valid); end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", inst_valid); end
  endtask

  task automatic test_store_branch_csr();
    inst_ready = 1'b1;
    send(4'd1, 5'd0, 5'd1, 5'd2, 32'd8);
    checks++; if (inst !== 32'h0020A423) begin errors++; $display("FAIL sw got %h exp 0020a423", inst); end
    send(4'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    checks++; if (inst !== 32'hFE208EE3) begin errors++; $display("FAIL beq got %h exp fe208ee3", inst); end
    send(4'd8, 5'd5, 5'd6, 5'd0, 32'h0000_0300);
    checks++; if (inst !== 32'h300312F3) begin errors++; $display("FAIL csrrw got %h exp 300312f3", inst); end
    step();
  endtask

  task automatic test_backpressure();
    int exp_idx;
    int next_imm;
    int guard;
    logic pop_now, acc_now;
    inst_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'(i));
      checks++; if (req_ready !== (i < 4)) begin errors++; $display("FAIL bp_ready_%0d got %b exp %b", i, req_ready, (i < 4)); end
    end
    // Requests 5 and 6 stall while the head holds steady.
    req_kind = 4'd2; req_rd = 5'd1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd5;
    req_valid = 1'b1;
    step(); step();
    checks++; if (req_ready !== 1'b0 || inst !== addi_w(1)) begin errors++; $display("FAIL bp_stall got %b/%h exp 0/%h", req_ready, inst, addi_w(1)); end
    inst_ready = 1'b1;
    exp_idx = 1; next_imm = 5; guard = 0;
    while (exp_idx <= 6 && guard < 40) begin
      pop_now = inst_valid & inst_ready;
      acc_now = req_valid & req_ready;
      if (pop_now) begin
        checks++; if (inst !== addi_w(exp_idx)) begin errors++; $display("FAIL bp_order_%0d got %h exp %h", exp_idx, inst, addi_w(exp_idx)); end
        exp_idx++;
      end
      step();
      guard++;
      if (acc_now) begin
        next_imm++;
        if (next_imm > 6) req_valid = 1'b0;
        else req_imm = 32'(next_imm);
      end
    end
    checks++; if (exp_idx != 7) begin errors++; $display("FAIL bp_timeout got %0d exp 7", exp_idx); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", inst_valid); end
    req_valid = 1'b0;
  endtask

  task automatic test_push_pop_full();
    inst_ready = 1'b0;
    for (int i = 20; i <= 23; i++) send(4'd2, 5'd1, 5'd0, 5'd0, 32'(i));
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ppf_full got %b exp 0", req_ready); end
    // Pop from full; the request waits because req_ready was low.
    inst_ready = 1'b1; req_imm = 32'd24; req_valid = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1 || inst !== addi_w(21)) begin errors++; $display("FAIL ppf_pop got %b/%h exp 1/%h", req_ready, inst, addi_w(21)); end
    // Simultaneous push and pop: occupancy unchanged, still not full.
    step();
    checks++; if (req_ready !== 1'b1 || inst !== addi_w(22)) begin errors++; $display("FAIL ppf_pushpop got %b/%h exp 1/%h", req_ready, inst, addi_w(22)); end
    req_imm = 32'd25; inst_ready = 1'b0;
    step();
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || inst !== addi_w(22)) begin errors++; $display("FAIL ppf_refill got %b/%h exp 0/%h", req_ready, inst, addi_w(22)); end
    inst_ready = 1'b1;
    for (int k = 23; k <= 25; k++) begin
      step();
      checks++; if (inst_valid !== 1'b1 || inst !== addi_w(k)) begin errors++; $display("FAIL ppf_order_%0d got %b/%h exp 1/%h", k, inst_valid, inst, addi_w(k)); end
    end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ppf_empty got %b exp 0", inst_valid); end
  endtask

  task automatic test_errors();
    inst_ready = 1'b1;
    send(4'd2, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd2 || inst_valid !== 1'b0) begin errors++; $display("FAIL err_imm got %b/%0d/%b exp 1/2/0", err_valid, err_code, inst_valid); end
    step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", err_valid); end
    send(4'd5, 5'd0, 5'd1, 5'd2, 32'd3);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd3 || inst_valid !== 1'b0) begin errors++; $display("FAIL err_align got %b/%0d/%b exp 1/3/0", err_valid, err_code, inst_valid); end
    send(4'd12, 5'd1, 5'd1, 5'd1, 32'd0);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd1 || inst_valid !== 1'b0) begin errors++; $display("FAIL err_kind got %b/%0d/%b exp 1/1/0", err_valid, err_code, inst_valid); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL err_count3 got %0d exp 3", err_count); end
    send(4'd6, 5'd0, 5'd1, 5'd2, 32'h0000_1000);
    checks++; if (err_code !== 2'd2 || err_count !== 8'd4) begin errors++; $display("FAIL err_bne_range got %0d/%0d exp 2/4", err_code, err_count); end
    send(4'd8, 5'd1, 5'd1, 5'd0, 32'h0000_1000);
    checks++; if (err_code !== 2'd2 || err_count !== 8'd5 || inst_valid !== 1'b0) begin errors++; $display("FAIL err_csr_range got %0d/%0d/%b exp 2/5/0", err_code, err_count, inst_valid); end
    step();
  endtask

  task automatic test_saturate();
    req_kind = 4'd12; req_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    checks++; if (err_count !== 8'd255 || err_valid !== 1'b1) begin errors++; $display("FAIL sat got %0d/%b exp 255/1", err_count, err_valid); end
    step();
    req_valid = 1'b0;
    checks++; if (err_count !== 8'd255 || inst_valid !== 1'b0) begin errors++; $display("FAIL sat_hold got %0d/%b exp 255/0", err_count, inst_valid); end
    step();
  endtask

  task automatic test_reset_midstream();
    inst_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(4'd2, 5'd1, 5'd0, 5'd0, 32'(i));
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mid_queued got %b exp 1", inst_valid); end
    req_imm = 32'd9; req_valid = 1'b1; resetn = 1'b0;
    step();
    resetn = 1'b1; req_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || err_count !== 8'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got %b/%0d/%b exp 0/0/1", inst_valid, err_count, req_ready); end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped got %b exp 0", inst_valid); end
    inst_ready = 1'b1;
    send(4'd4, 5'd3, 5'd1, 5'd2, 32'd0);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h402081B3) begin errors++; $display("FAIL mid_resume got %b/%h exp 1/402081b3", inst_valid, inst); end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
    req_kind = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    test_reset();
    test_basic();
    test_store_branch_csr();
    test_backpressure();
    test_push_pop_full();
    test_errors();
    test_saturate();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
